// File: rtl/piso_tx_shift_register.sv
// Parallel-in, serial-out USB bit transmitter with a one-byte holding buffer
// and optional bit-stuff insertion after six consecutive transmitted ones.
//
// Ports:
//   clk          system clock, rising edge
//   nRST         asynchronous active-low reset
//   shift_enable bit-time strobe; advances the serial stream by one bit
//   data_in      byte to transmit
//   load         data_in valid; accepted when load && load_ready
//   load_ready   holding buffer empty
//   serial_out   current transmitted bit (IDLE_LEVEL while idle)
//   busy         high whenever the transmitter is not idle
//   byte_done    one-cycle pulse after the last data bit of a byte shifts out
//   stuff_active high while serial_out carries an inserted stuff zero
module piso_tx_shift_register #(
  parameter bit   STUFF_EN   = 1'b1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       shift_enable,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       load_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       byte_done,
  output logic       stuff_active
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ONES_W = 3;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ONES_W-1:0] STUFF_RUN = ONES_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_e;

  state_e              state_q,        state_d;
  logic [DATA_W-1:0]   shift_q,        shift_d;
  logic [DATA_W-1:0]   hold_q,         hold_d;
  logic                hold_valid_q,   hold_valid_d;
  logic [CNT_W-1:0]    bit_cnt_q,      bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt_q,     ones_cnt_d;
  logic                load_ready_q,   load_ready_d;
  logic                serial_q,       serial_d;
  logic                busy_q,         busy_d;
  logic                byte_done_q,    byte_done_d;
  logic                stuff_q,        stuff_d;

  logic                accept_c;
  logic                stuff_now_c;
  logic [ONES_W-1:0]   ones_next_c;

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    byte_done_d  = 1'b0;

    accept_c    = load && load_ready_q;
    stuff_now_c = STUFF_EN && (state_q == ST_SHIFT) && (ones_cnt_q == STUFF_RUN);
    ones_next_c = shift_q[DATA_W-1] ? ones_cnt_q + ONES_W'(1) : '0;

    unique case (state_q)
      ST_IDLE: begin
        // Hold-to-shift transfer does not wait for a bit strobe
        if (hold_valid_q) begin
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          bit_cnt_d    = '0;
          ones_cnt_d   = '0;
          state_d      = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (shift_enable) begin
          if (stuff_now_c) begin
            // Stuff bit consumes a bit time without touching the data
            ones_cnt_d = '0;
          end else begin
            ones_cnt_d = ones_next_c;
            shift_d    = shift_q << 1;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              byte_done_d = 1'b1;
              if (hold_valid_q) begin
                // Chain the next byte; ones run carries across the boundary
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
                bit_cnt_d    = '0;
              end else if (STUFF_EN && (ones_next_c == STUFF_RUN)) begin
                state_d = ST_TAIL;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end

      ST_TAIL: begin
        if (shift_enable) begin
          ones_cnt_d = '0;
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_cnt_d    = '0;
            state_d      = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Acceptance only happens with an empty buffer, so it never races a transfer
    if (accept_c) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end

    // Outputs are registered from the next state so they track the state exactly
    load_ready_d = !hold_valid_d;
    busy_d       = (state_d != ST_IDLE);
    stuff_d      = (state_d == ST_TAIL) ||
                   (STUFF_EN && (state_d == ST_SHIFT) && (ones_cnt_d == STUFF_RUN));
    if (state_d == ST_IDLE) begin
      serial_d = IDLE_LEVEL;
    end else if (stuff_d) begin
      serial_d = 1'b0;
    end else begin
      serial_d = shift_d[DATA_W-1];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      load_ready_q <= 1'b1;
      serial_q     <= IDLE_LEVEL;
      busy_q       <= 1'b0;
      byte_done_q  <= 1'b0;
      stuff_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      load_ready_q <= load_ready_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      byte_done_q  <= byte_done_d;
      stuff_q      <= stuff_d;
    end
  end

  assign load_ready   = load_ready_q;
  assign serial_out   = serial_q;
  assign busy         = busy_q;
  assign byte_done    = byte_done_q;
  assign stuff_active = stuff_q;

endmodule

// File: tb/tb_piso_tx_shift_register.sv
// Testbench for piso_tx_shift_register: directed scenarios plus random traffic,
// checked every cycle against a bit-stream reference model.
module tb_piso_tx_shift_register;

  localparam bit   STUFF_EN   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  logic       clk = 1'b0;
  logic       nRST;
  logic       shift_enable;
  logic [7:0] data_in;
  logic       load;
  logic       load_ready;
  logic       serial_out;
  logic       busy;
  logic       byte_done;
  logic       stuff_active;

  always #5 clk = ~clk;

  piso_tx_shift_register #(
    .STUFF_EN   (STUFF_EN),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk          (clk),
    .nRST         (nRST),
    .shift_enable (shift_enable),
    .data_in      (data_in),
    .load         (load),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .busy         (busy),
    .byte_done    (byte_done),
    .stuff_active (stuff_active)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Reference model: a queue of data bits still to be sent, a one-byte
  // waiting slot, the current run of ones, and whether the link is streaming.
  bit         exp_bits[$];
  bit         m_busy;
  bit         m_tail;
  bit         m_wait_v;
  logic [7:0] m_wait;
  bit         m_done;
  int         m_ones;

  task automatic model_reset();
    exp_bits.delete();
    m_busy   = 1'b0;
    m_tail   = 1'b0;
    m_wait_v = 1'b0;
    m_wait   = 8'h00;
    m_done   = 1'b0;
    m_ones   = 0;
  endtask

  task automatic start_byte();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(m_wait[i]);
    m_wait_v = 1'b0;
  endtask

  // Monitor: sample away from the rising edge, compare, then advance the model
  always @(negedge clk) begin
    bit   acc;
    bit   b;
    logic exp_stuff;
    logic exp_ser;
    if (!nRST) begin
      chk("rst_load_ready", load_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_byte_done", byte_done, 1'b0);
      chk("rst_stuff", stuff_active, 1'b0);
      chk("rst_serial", serial_out, IDLE_LEVEL);
      model_reset();
    end else begin
      exp_stuff = m_busy && (m_tail || (STUFF_EN && m_ones == 6));
      if (!m_busy)        exp_ser = IDLE_LEVEL;
      else if (exp_stuff) exp_ser = 1'b0;
      else if (exp_bits.size() == 0) begin
        exp_ser = 1'b0;
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty at %0t: got 0 queued bits expected >0", $time);
      end else exp_ser = exp_bits[0];

      chk("busy", busy, m_busy);
      chk("load_ready", load_ready, !m_wait_v);
      chk("byte_done", byte_done, m_done);
      chk("stuff_active", stuff_active, exp_stuff);
      chk("serial_out", serial_out, exp_ser);

      acc    = load && !m_wait_v;
      m_done = 1'b0;
      if (!m_busy) begin
        if (m_wait_v) begin
          start_byte();
          m_ones = 0;
          m_busy = 1'b1;
        end
      end else if (m_tail) begin
        if (shift_enable) begin
          m_ones = 0;
          m_tail = 1'b0;
          if (m_wait_v) start_byte();
          else          m_busy = 1'b0;
        end
      end else if (shift_enable) begin
        if (STUFF_EN && m_ones == 6) begin
          m_ones = 0;
        end else if (exp_bits.size() != 0) begin
          b      = exp_bits.pop_front();
          m_ones = b ? m_ones + 1 : 0;
          if (exp_bits.size() == 0) begin
            m_done = 1'b1;
            if (m_wait_v)                       start_byte();
            else if (STUFF_EN && m_ones == 6)   m_tail = 1'b1;
            else                                m_busy = 1'b0;
          end
        end
      end
      if (acc) begin
        m_wait   = data_in;
        m_wait_v = 1'b1;
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge
  task automatic tick(input logic ld, input logic [7:0] d, input logic se);
    load         = ld;
    data_in      = d;
    shift_enable = se;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic strobes(input int n, input int gap);
    repeat (n) begin
      tick(1'b0, 8'h00, 1'b1);
      idle(gap);
    end
  endtask

  task automatic send(input logic [7:0] d, input int n_strobes);
    tick(1'b1, d, 1'b0);
    idle(2);
    strobes(n_strobes, 1);
    idle(3);
  endtask

  logic [7:0] ones_tbl [6] = '{8'hFF, 8'h7F, 8'hFE, 8'h3F, 8'hFC, 8'h7E};

  initial begin
    logic [7:0] d;
    model_reset();
    nRST         = 1'b0;
    load         = 1'b0;
    shift_enable = 1'b0;
    data_in      = 8'h00;
    repeat (3) @(posedge clk);
    #1 nRST = 1'b1;
    idle(2);

    // Plain byte, a stuffed byte, a byte ending in a tail stuff bit
    send(8'hA5, 8);
    send(8'hFF, 9);
    send(8'h3F, 9);

    // Back-to-back pair with no idle bit between them
    tick(1'b1, 8'h3C, 1'b0);
    idle(2);
    strobes(2, 1);
    tick(1'b1, 8'hC3, 1'b0);
    strobes(14, 1);
    idle(3);

    // Slow strobes, plus a load offered while the buffer is full
    tick(1'b1, 8'h55, 1'b0);
    idle(2);
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    strobes(17, 4);
    idle(3);

    // Reset in the middle of a byte, then a clean byte
    tick(1'b1, 8'hF0, 1'b0);
    idle(2);
    strobes(3, 1);
    nRST = 1'b0;
    idle(3);
    nRST = 1'b1;
    idle(1);
    send(8'h81, 8);

    // Random traffic biased toward long runs of ones
    repeat (4000) begin
      d = ($urandom_range(0, 1) == 0) ? ones_tbl[$urandom_range(0, 5)] : 8'($urandom);
      tick($urandom_range(0, 3) == 0, d, $urandom_range(0, 2) == 0);
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
